// File: rtl/hwt_monitor.sv
// Runtime checker for the hwt cell: compares sampled vectors against Y = D & ((A & B) ^ C).
// It counts mismatches per rolling window and latches an alarm. Optional capture of the first bad vector: HWT_MON_TRACE_EN.
module hwt_monitor #(
    parameter int unsigned MISMATCH_LIMIT = 4,
    parameter int unsigned WINDOW         = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       a,
    input  logic                       b,
    input  logic                       c,
    input  logic                       d,
    input  logic                       y,
    output logic                       alarm,
    output logic [CNT_W-1:0]           err_cnt,
    output logic [$clog2(WINDOW)-1:0]  sample_cnt,
    output logic [1:0]                 state,
    output logic [4:0]                 trace_vec,
    output logic                       trace_valid
);

    localparam int unsigned SMP_W = $clog2(WINDOW);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] MONITOR = 2'b01;
    localparam logic [1:0] ALARM   = 2'b10;

    localparam logic [CNT_W-1:0] LIMIT       = CNT_W'(MISMATCH_LIMIT);
    localparam logic [SMP_W-1:0] LAST_SAMPLE = SMP_W'(WINDOW - 1);

    logic             golden;
    logic             accept;
    logic             mismatch;
    logic [1:0]       state_d;
    logic             alarm_d;
    logic [CNT_W-1:0] err_d;
    logic [CNT_W-1:0] err_inc;
    logic [SMP_W-1:0] smp_d;

    assign in_ready = (state == MONITOR);
    assign accept   = in_valid && in_ready;
    assign golden   = d & ((a & b) ^ c);
    assign mismatch = accept && (y != golden);

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alarm      <= 1'b0;
            err_cnt    <= '0;
            sample_cnt <= '0;
        end else begin
            state      <= state_d;
            alarm      <= alarm_d;
            err_cnt    <= err_d;
            sample_cnt <= smp_d;
        end
    end

    // Next-state: clear > en low > limit reached > window rollover
    always_comb begin
        state_d = state;
        alarm_d = alarm;
        err_d   = err_cnt;
        smp_d   = sample_cnt;
        err_inc = err_cnt + CNT_W'(1);

        if (clear) begin
            err_d   = '0;
            smp_d   = '0;
            alarm_d = 1'b0;
            if (state == ALARM) begin
                state_d = IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    err_d = '0;
                    smp_d = '0;
                    if (en) begin
                        state_d = MONITOR;
                    end
                end
                MONITOR: begin
                    if (!en) begin
                        state_d = IDLE;
                        err_d   = '0;
                        smp_d   = '0;
                    end else if (accept) begin
                        smp_d = sample_cnt + SMP_W'(1);
                        if (mismatch) begin
                            err_d = err_inc;
                        end
                        if (mismatch && (err_inc == LIMIT)) begin
                            state_d = ALARM;
                            alarm_d = 1'b1;
                        end else if (sample_cnt == LAST_SAMPLE) begin
                            smp_d = '0;
                            err_d = '0;
                        end
                    end
                end
                ALARM: begin
                    alarm_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    alarm_d = 1'b0;
                    err_d   = '0;
                    smp_d   = '0;
                end
            endcase
        end
    end

`ifdef HWT_MON_TRACE_EN
    logic capture;

    // Only a mismatch that is actually counted may be captured
    assign capture = mismatch && en && !clear && !trace_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_vec   <= '0;
            trace_valid <= 1'b0;
        end else if (clear) begin
            trace_vec   <= '0;
            trace_valid <= 1'b0;
        end else if (capture) begin
            trace_vec   <= {a, b, c, d, y};
            trace_valid <= 1'b1;
        end
    end
`else
    assign trace_vec   = 5'b00000;
    assign trace_valid = 1'b0;
`endif

endmodule

// File: doc/hwt_monitor.md
# hwt_monitor

Runtime checker for the `hwt` combinational cell. It sits on the consuming side of that cell and samples the cell's inputs and observed output through a valid/ready port. Each accepted sample is compared against the golden function `Y = D & ((A & B) ^ C)`. Mismatches are counted over a rolling sample window, and a sticky alarm is raised when the count reaches a limit, flagging a tampered or faulty `hwt` instance.

## Interface
Parameters:
- `MISMATCH_LIMIT`, default 4: mismatches within one window that trigger the alarm; legal range 1..WINDOW.
- `WINDOW`, default 16: accepted samples per window; must be a power of two, at least 2.
- `CNT_W`, default 8: width of `err_cnt`; must satisfy 2^CNT_W > MISMATCH_LIMIT.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `en`, in, 1: monitor enable.
- `clear`, in, 1: synchronous clear of counters and alarm.
- `in_valid`, in, 1: sample valid.
- `in_ready`, out, 1: monitor accepts a sample.
- `a`, `b`, `c`, `d`, in, 1 each: sampled `hwt` inputs.
- `y`, in, 1: observed `hwt` output.
- `alarm`, out, 1: sticky tamper flag.
- `err_cnt`, out, CNT_W: mismatches in the current window.
- `sample_cnt`, out, log2(WINDOW): accepted samples in the current window.
- `state`, out, 2: FSM state; IDLE=2'b00, MONITOR=2'b01, ALARM=2'b10.
- `trace_vec`, out, 5: captured vector `{a,b,c,d,y}`.
- `trace_valid`, out, 1: `trace_vec` holds a capture.

## Operation
- Accept condition: `in_valid && in_ready`. `in_ready` = (state == MONITOR) and is combinational from the state register.
- `golden = d & ((a & b) ^ c)`. Mismatch = accept and (`y != golden`).
- IDLE:
  - Counters are held at 0.
  - Moves to MONITOR when `en` = 1.
- MONITOR, per accept:
  - `sample_cnt` increments.
  - On a mismatch, `err_cnt` increments.
  - When the new `err_cnt` equals MISMATCH_LIMIT: go to ALARM and set `alarm` = 1.
  - Otherwise, when the accepted sample is number WINDOW in the window (`sample_cnt` was WINDOW-1): `sample_cnt` wraps to 0 and `err_cnt` is cleared to 0.
- MONITOR, `en` = 0:
  - Go to IDLE and zero both counters. This takes effect even on a cycle with an accept; that sample is discarded.
- ALARM:
  - `alarm` holds at 1, `in_ready` = 0, and counters are frozen.
  - `en` is ignored.
  - Only `clear` or `rst_n` exits.
- `clear` = 1 in any state:
  - Zero `err_cnt`, `sample_cnt`, and `alarm`.
  - From ALARM go to IDLE. From MONITOR stay in MONITOR. Any accept in the same cycle is discarded.
- Priority, highest first: `rst_n`, `clear`, `en` = 0, limit reached, window rollover.
- A mismatch on the last sample of a window that reaches the limit gives ALARM. The frozen state is `err_cnt` = MISMATCH_LIMIT and `sample_cnt` = 0.
- `err_cnt` never exceeds MISMATCH_LIMIT.

## Timing
- Reset values:
  - `state` = IDLE.
  - `alarm`, `err_cnt`, `sample_cnt`, `trace_vec`, `trace_valid` all 0.
  - `in_ready` = 0.
- Reset takes effect immediately on the falling edge of `rst_n`, with no dependence on the clock. Release is synchronous to the next `clk` edge.
- Reset mid-window discards all counts.
- The sample is accepted on clock edge N. `err_cnt`, `sample_cnt`, `state`, and `alarm` reflect it after edge N, with a latency of 1 cycle.
- Entering ALARM at edge N drops `in_ready` after edge N, so no further accept can occur.
- `en` rising in IDLE at edge N gives `in_ready` = 1 from edge N onward. The first accept is possible at edge N+1.
- Throughput: one sample per cycle while in MONITOR.
- All outputs except `in_ready` are registered.

## Configuration
- `HWT_MON_TRACE_EN` defined:
  - On the first mismatch since reset or `clear`, capture `{a,b,c,d,y}` into `trace_vec` and set `trace_valid` = 1.
  - Later mismatches do not overwrite the capture.
  - `clear` zeroes both outputs.
  - Window rollover does not clear the capture.
- `HWT_MON_TRACE_EN` undefined:
  - `trace_vec` and `trace_valid` are constant 0 and the capture registers are not built.
  - The port list is unchanged.

## Test plan
- Reset check: assert `rst_n` = 0 mid-cycle -> immediately `state` = 2'b00, `alarm` = 0, `err_cnt` = 0, `sample_cnt` = 0, `in_ready` = 0.
- Clean stream: `en` = 1, 32 golden-consistent samples -> `err_cnt` stays 0, `sample_cnt` wraps from 15 to 0 twice, `alarm` stays 0.
- Alarm trip: 4 mismatches inside one window (for example `a=1,b=1,c=0,d=1,y=0`) -> after the 4th accept edge, `state` = 2'b10, `alarm` = 1, `in_ready` = 0, `err_cnt` = 4.
- Window rollover: 3 mismatches in window 1, then 3 mismatches in window 2 -> `err_cnt` returns to 0 at the rollover edge and `alarm` never asserts.
- Clear/priority: in ALARM pulse `clear` -> next cycle IDLE, `alarm` = 0. In MONITOR, `clear` together with a mismatching accept -> `err_cnt` = 0.
- Trace (`HWT_MON_TRACE_EN`): first mismatch `a=1,b=1,c=1,d=1,y=1` then a second mismatch `0,0,1,1,0` -> `trace_vec` = 5'b11111, `trace_valid` = 1, held. Without the macro -> both stay 0.
